// File: rtl/adc_fmt_pkg.sv
// Shared types and the raw-ADC-code to two's-complement conversion used by the
// ADC receiver path.
package adc_fmt_pkg;

  typedef enum logic [1:0] {
    FMT_2C     = 2'd0,
    FMT_OB     = 2'd1,
    FMT_GRAY   = 2'd2,
    FMT_INV_OB = 2'd3
  } fmt_mode_t;

  localparam int FMT_MAX_W = 16;

  // raw must be zero-extended from in_w bits; bits at and above in_w return 0.
  function automatic logic [FMT_MAX_W-1:0] fmt_to_2c(input logic [FMT_MAX_W-1:0] raw,
                                                     input fmt_mode_t mode,
                                                     input int in_w);
    logic [FMT_MAX_W-1:0] r;
    r = '0;
    case (mode)
      FMT_2C, FMT_OB: r = raw;
      FMT_GRAY: begin
        for (int k = FMT_MAX_W - 1; k >= 0; k--) begin
          if (k < in_w - 1) r[k] = r[k+1] ^ raw[k];
          else              r[k] = raw[k];
        end
      end
      FMT_INV_OB: r = ~raw;
      default: r = raw;
    endcase
    if (mode != FMT_2C) r[in_w-1] = ~r[in_w-1];
    for (int k = 0; k < FMT_MAX_W; k++) begin
      if (k >= in_w) r[k] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_ovr_cnt.sv
// Single saturating overrange event counter; a clear takes priority over an
// increment in the same cycle.
module adc_ovr_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/adc_fmt_conv.sv
// Two-stage converter from runtime-selected ADC raw coding to sign-extended
// two's complement, with frame-aligned mode switching and overrange counters.
module adc_fmt_conv
  import adc_fmt_pkg::*;
#(
  parameter int PORTS = 8,
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [PORTS-1:0][IN_W-1:0]  DATA_IN,
  input  logic                        VALID_IN,
  input  logic                        SOF_IN,
  input  logic [1:0]                  MODE,
  input  logic                        CLR_CNT,
  output logic [PORTS-1:0][OUT_W-1:0] DATA_OUT,
  output logic                        VALID_OUT,
  output logic                        SOF_OUT,
  output logic [PORTS-1:0]            OVR_FLAG,
  output logic [PORTS-1:0][CNT_W-1:0] OVR_CNT,
  output logic [1:0]                  MODE_ACT
);

  localparam logic [IN_W-1:0] FS_NEG = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0] FS_POS = ~FS_NEG;

  fmt_mode_t mode_act_q, mode_eff;

  logic [PORTS-1:0][IN_W-1:0]  data_p1_q;
  logic                        vld_p1_q, sof_p1_q;
  fmt_mode_t                   mode_p1_q;

  logic [PORTS-1:0][IN_W-1:0]  conv_p1;
  logic [PORTS-1:0][OUT_W-1:0] data_p2_q, data_p2_d;
  logic [PORTS-1:0]            ovr_p2_q, ovr_p2_d;
  logic                        vld_p2_q, sof_p2_q;

  function automatic logic [OUT_W-1:0] sext(input logic [IN_W-1:0] v);
    logic signed [IN_W-1:0]  s;
    logic signed [OUT_W-1:0] r;
    s = v;
    r = s;
    return r;
  endfunction

  // A start-of-frame beat both latches the new mode and is converted with it.
  assign mode_eff = (VALID_IN && SOF_IN) ? fmt_mode_t'(MODE) : mode_act_q;

  always_comb begin
    conv_p1   = '0;
    data_p2_d = data_p2_q;
    ovr_p2_d  = '0;
    for (int i = 0; i < PORTS; i++) begin
      conv_p1[i] = IN_W'(fmt_to_2c(FMT_MAX_W'(data_p1_q[i]), mode_p1_q, IN_W));
      if (vld_p1_q) begin
        data_p2_d[i] = sext(conv_p1[i]);
        ovr_p2_d[i]  = (conv_p1[i] == FS_NEG) || (conv_p1[i] == FS_POS);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_act_q <= FMT_2C;
      data_p1_q  <= '0;
      vld_p1_q   <= 1'b0;
      sof_p1_q   <= 1'b0;
      mode_p1_q  <= FMT_2C;
      data_p2_q  <= '0;
      vld_p2_q   <= 1'b0;
      sof_p2_q   <= 1'b0;
      ovr_p2_q   <= '0;
    end else begin
      // stage 1: capture raw beat and its effective mode
      mode_act_q <= mode_eff;
      data_p1_q  <= DATA_IN;
      vld_p1_q   <= VALID_IN;
      sof_p1_q   <= SOF_IN & VALID_IN;
      mode_p1_q  <= mode_eff;
      // stage 2: converted sample and overrange flag
      data_p2_q  <= data_p2_d;
      vld_p2_q   <= vld_p1_q;
      sof_p2_q   <= sof_p1_q;
      ovr_p2_q   <= ovr_p2_d;
    end
  end

  for (genvar i = 0; i < PORTS; i++) begin : g_cnt
    adc_ovr_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_i (CLK),
      .rst_i (RST),
      .clr_i (CLR_CNT),
      .inc_i (ovr_p2_d[i]),
      .cnt_o (OVR_CNT[i])
    );
  end

  assign DATA_OUT  = data_p2_q;
  assign VALID_OUT = vld_p2_q;
  assign SOF_OUT   = sof_p2_q;
  assign OVR_FLAG  = ovr_p2_q;
  assign MODE_ACT  = mode_act_q;

endmodule

// File: tb/tb_adc_fmt_conv.sv
// Scoreboard bench for adc_fmt_conv: random and directed beats, expected
// results from an arithmetic reference model, checked by a separate monitor.
module tb_adc_fmt_conv;

  localparam int PORTS = 4;
  localparam int IN_W  = 12;
  localparam int OUT_W = 16;
  localparam int CNT_W = 4;

  logic                        CLK = 1'b0;
  logic                        RST;
  logic [PORTS-1:0][IN_W-1:0]  DATA_IN;
  logic                        VALID_IN, SOF_IN, CLR_CNT;
  logic [1:0]                  MODE;
  logic [PORTS-1:0][OUT_W-1:0] DATA_OUT;
  logic                        VALID_OUT, SOF_OUT;
  logic [PORTS-1:0]            OVR_FLAG;
  logic [PORTS-1:0][CNT_W-1:0] OVR_CNT;
  logic [1:0]                  MODE_ACT;

  adc_fmt_conv #(.PORTS(PORTS), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .VALID_IN(VALID_IN), .SOF_IN(SOF_IN),
    .MODE(MODE), .CLR_CNT(CLR_CNT), .DATA_OUT(DATA_OUT), .VALID_OUT(VALID_OUT),
    .SOF_OUT(SOF_OUT), .OVR_FLAG(OVR_FLAG), .OVR_CNT(OVR_CNT), .MODE_ACT(MODE_ACT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [PORTS-1:0][OUT_W-1:0] data;
    logic [PORTS-1:0]            flag;
    logic                        sof;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   mdl_mode = 0;
  int   mdl_cnt[PORTS];
  logic [PORTS-1:0][OUT_W-1:0] last_data = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Signed value the raw code represents, from the coding definitions.
  function automatic int ref_val(input int raw, input int mode);
    int half, b;
    half = 1 << (IN_W - 1);
    case (mode)
      0: return (raw >= half) ? raw - 2 * half : raw;
      1: return raw - half;
      2: begin
        b = raw;
        for (int sh = 1; sh < IN_W; sh++) b = b ^ (raw >> sh);
        return b - half;
      end
      default: return half - 1 - raw;
    endcase
  endfunction

  function automatic exp_t expect_beat(input logic [PORTS-1:0][IN_W-1:0] d, input int m,
                                       input bit s);
    exp_t e;
    int   v;
    for (int i = 0; i < PORTS; i++) begin
      v         = ref_val(int'(d[i]), m);
      e.data[i] = OUT_W'(v);
      e.flag[i] = (v == -(1 << (IN_W - 1))) || (v == (1 << (IN_W - 1)) - 1);
    end
    e.sof = s;
    return e;
  endfunction

  task automatic drive(input bit v, input bit s, input int m,
                       input logic [PORTS-1:0][IN_W-1:0] d, input bit c);
    @(negedge CLK);
    chk("mode_act", 128'(MODE_ACT), 128'(mdl_mode));
    VALID_IN = v; SOF_IN = s; MODE = 2'(m); DATA_IN = d; CLR_CNT = c;
    if (v) begin
      if (s) mdl_mode = m;
      sb.push_back(expect_beat(d, mdl_mode, s));
    end
  endtask

  function automatic logic [PORTS-1:0][IN_W-1:0] rand_data();
    logic [PORTS-1:0][IN_W-1:0] d;
    logic [IN_W-1:0] fs[6];
    fs[0] = 12'h000; fs[1] = 12'hFFF; fs[2] = 12'h7FF;
    fs[3] = 12'h800; fs[4] = 12'h400; fs[5] = 12'hC00;
    for (int i = 0; i < PORTS; i++) begin
      if ($urandom_range(0, 3) == 0) d[i] = fs[$urandom_range(0, 5)];
      else                           d[i] = IN_W'($urandom);
    end
    return d;
  endfunction

  function automatic logic [PORTS-1:0][IN_W-1:0] fill(input logic [IN_W-1:0] v);
    logic [PORTS-1:0][IN_W-1:0] d;
    for (int i = 0; i < PORTS; i++) d[i] = v;
    return d;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a beat.
  initial begin
    logic                        clr_s;
    logic [PORTS-1:0]            cur_flag;
    logic [PORTS-1:0][CNT_W-1:0] mc;
    exp_t                        e;
    for (int i = 0; i < PORTS; i++) mdl_cnt[i] = 0;
    forever begin
      @(posedge CLK);
      clr_s = CLR_CNT;
      #1;
      if (RST) begin
        chk("rst_valid", 128'(VALID_OUT), 128'(0));
        chk("rst_data", 128'(DATA_OUT), 128'(0));
        chk("rst_flag_sof", 128'({OVR_FLAG, SOF_OUT}), 128'(0));
        chk("rst_cnt", 128'(OVR_CNT), 128'(0));
        chk("rst_mode", 128'(MODE_ACT), 128'(0));
        for (int i = 0; i < PORTS; i++) mdl_cnt[i] = 0;
        last_data = '0;
        continue;
      end
      cur_flag = '0;
      if (VALID_OUT) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 128'(1), 128'(0));
        end else begin
          e = sb.pop_front();
          chk("data", 128'(DATA_OUT), 128'(e.data));
          chk("ovr_flag", 128'(OVR_FLAG), 128'(e.flag));
          chk("sof", 128'(SOF_OUT), 128'(e.sof));
          last_data = e.data;
          cur_flag  = e.flag;
        end
      end else begin
        chk("idle_hold", 128'(DATA_OUT), 128'(last_data));
        chk("idle_flag_sof", 128'({OVR_FLAG, SOF_OUT}), 128'(0));
      end
      for (int i = 0; i < PORTS; i++) begin
        if (clr_s)            mdl_cnt[i] = 0;
        else if (cur_flag[i]) mdl_cnt[i] = (mdl_cnt[i] >= (1 << CNT_W) - 1) ? mdl_cnt[i]
                                                                           : mdl_cnt[i] + 1;
        mc[i] = CNT_W'(mdl_cnt[i]);
      end
      chk("ovr_cnt", 128'(OVR_CNT), 128'(mc));
    end
  end

  initial begin
    logic [PORTS-1:0][IN_W-1:0] d;
    RST = 1'b1; VALID_IN = 1'b0; SOF_IN = 1'b0; MODE = 2'd0; CLR_CNT = 1'b0; DATA_IN = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    // Directed codings: offset binary, Gray, inverted offset binary.
    d[0] = 12'h800; d[1] = 12'h000; d[2] = 12'hFFF; d[3] = 12'h001;
    drive(1, 1, 1, d, 0);
    d[0] = 12'hC00; d[1] = 12'h800; d[2] = 12'h000; d[3] = 12'h001;
    drive(1, 1, 2, d, 0);
    d[0] = 12'hFFE; d[1] = 12'hFFF; d[2] = 12'h000; d[3] = 12'h800;
    drive(1, 1, 3, d, 0);

    // Mode request without SOF must not take effect mid-frame.
    drive(1, 1, 1, fill(12'h123), 0);
    drive(1, 0, 0, fill(12'h456), 0);
    drive(0, 1, 0, fill(12'h789), 0);
    drive(1, 0, 0, fill(12'hABC), 0);
    drive(1, 1, 0, fill(12'hABC), 0);
    drive(0, 0, 0, fill(12'h000), 0);

    // Counter saturation, then a clear during a flagged stream.
    drive(1, 1, 1, fill(12'h000), 0);
    repeat (19) drive(1, 0, 0, fill(12'h000), 0);
    drive(1, 0, 0, fill(12'hFFF), 1);
    drive(1, 0, 0, fill(12'h000), 0);
    drive(1, 0, 0, fill(12'h000), 0);

    // Randomized traffic with occasional frame starts, idles and clears.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3),
            rand_data(), $urandom_range(0, 31) == 0);
    end

    // One-cycle reset with VALID_IN held high.
    @(negedge CLK);
    chk("mode_act_pre_rst", 128'(MODE_ACT), 128'(mdl_mode));
    RST = 1'b1; VALID_IN = 1'b1; SOF_IN = 1'b0; DATA_IN = rand_data(); CLR_CNT = 1'b0;
    sb.delete();
    mdl_mode = 0;
    @(negedge CLK);
    RST = 1'b0;
    DATA_IN = rand_data();
    sb.push_back(expect_beat(DATA_IN, 0, 0));
    for (int n = 0; n < 40; n++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 5) == 0, $urandom_range(0, 3),
            rand_data(), 0);
    end

    repeat (4) drive(0, 0, 0, fill(12'h000), 0);
    @(negedge CLK);
    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_fmt_conv.md
Name: adc_fmt_conv

Overview:
- Parametrised successor to the fixed 8-bit, 8-port offset-binary to two's-complement converter in the ADC receiver path.
- Converts PORTS parallel ADC samples of any width from a runtime-selected raw coding to two's complement, sign-extended to OUT_W.
- Registered 2-stage pipeline with a valid qualifier, a frame-aligned mode update, and per-channel saturating overrange counters.
- Sits between the ADC deserialiser output and the DSP front end.

Parameters:
- PORTS, 8, number of parallel samples (channels) per beat.
- IN_W, 8, raw sample width in bits, valid range 2..16.
- OUT_W, 8, output sample width in bits, OUT_W >= IN_W; result is sign-extended.
- CNT_W, 16, width of each overrange counter.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- DATA_IN  in  [PORTS-1:0][IN_W-1:0]  raw ADC samples.
- VALID_IN  in  1  DATA_IN qualifier.
- SOF_IN  in  1  start-of-frame marker, meaningful only when VALID_IN=1.
- MODE  in  2  requested coding: 0 passthrough (already 2C), 1 offset binary, 2 Gray-coded offset binary, 3 inverted offset binary.
- CLR_CNT  in  1  synchronous clear pulse for all overrange counters.
- DATA_OUT  out  [PORTS-1:0][OUT_W-1:0]  two's-complement samples.
- VALID_OUT  out  1  DATA_OUT qualifier.
- SOF_OUT  out  1  SOF_IN delayed to match DATA_OUT.
- OVR_FLAG  out  [PORTS-1:0]  per-channel flag: the current output sample was a full-scale code.
- OVR_CNT  out  [PORTS-1:0][CNT_W-1:0]  per-channel overrange count.
- MODE_ACT  out  2  coding mode currently in effect.

Behaviour:
- Reset: all outputs, pipeline registers and counters are 0. MODE_ACT=0.
- Interface: no backpressure. Every VALID_IN beat produces exactly one VALID_OUT beat 2 cycles later (latency 2, throughput 1 beat/cycle).
- Mode latch:
  - MODE is captured into MODE_ACT on a beat with VALID_IN=1 and SOF_IN=1. That beat, and all later beats, use the new mode.
  - On all other cycles MODE changes are ignored, so a mode never changes mid-frame.
- Stage 1 register: captures DATA_IN, VALID_IN, SOF_IN and the effective mode for that beat, i.e. the new MODE if the beat latches it, otherwise MODE_ACT.
- Stage 2 conversion and register, computed per channel from the stage-1 mode:
  - Mode 0: value unchanged.
  - Mode 1: invert the MSB.
  - Mode 2: Gray to binary, b[IN_W-1]=g[IN_W-1] and b[k]=b[k+1]^g[k]; then invert the MSB.
  - Mode 3: invert all bits, then invert the MSB.
  - The IN_W-bit result is sign-extended to OUT_W.
- Overrange:
  - OVR_FLAG[i]=1 when the converted 2C value equals -2^(IN_W-1) or 2^(IN_W-1)-1 and the beat is valid. It is registered alongside DATA_OUT.
  - OVR_CNT[i] increments by one each cycle OVR_FLAG[i] is set, and saturates at all-ones.
  - CLR_CNT=1 zeroes all counters. If it coincides with an increment, the clear wins and the result is 0, not 1.
- Invalid beats: when VALID_OUT=0, DATA_OUT holds its last value, OVR_FLAG=0, SOF_OUT=0.
- Reset mid-stream: in-flight beats are discarded and no VALID_OUT pulses appear after RST is released until new input arrives.

Decomposition:
- Package adc_fmt_pkg holds:
  - enum fmt_mode_t {FMT_2C, FMT_OB, FMT_GRAY, FMT_INV_OB};
  - the conversion function fmt_to_2c(raw, mode) parametrised by IN_W, reused by later blocks.
- Sub-module adc_ovr_cnt: one saturating counter with clear, instantiated PORTS times by a generate loop.

Test Plan:
- Mode 1, IN_W=8, OUT_W=8, DATA_IN ch0=0x80, ch1=0x00, ch2=0xFF, VALID_IN=1 -> 2 cycles later DATA_OUT=0x00, 0x80, 0x7F; OVR_FLAG ch1 and ch2 set.
- Mode 2, IN_W=8, Gray 0xC0 (binary 0x80) -> DATA_OUT=0x00; Gray 0x80 (binary 0xFF) -> 0x7F.
- IN_W=12, OUT_W=16, mode 1, raw 0x001 -> DATA_OUT=0xF801; mode 3, raw 0xFFE -> 0xF801.
- MODE changed 1->0 mid-frame without SOF -> conversion stays mode 1 and MODE_ACT=1. Next SOF beat with MODE=0 -> that beat is passed through unchanged and MODE_ACT=0.
- CNT_W=4, 20 consecutive full-scale beats -> OVR_CNT saturates at 0xF. CLR_CNT asserted in the same cycle as a flagged beat -> count reads 0.
- RST asserted for 1 cycle while VALID_IN is held high -> all outputs 0 during and after reset, and VALID_OUT returns 2 cycles after the first post-reset valid beat.
